packet_consumer: RTL and testbench

PACKET_CONSUMER -- requirements
Module: packet_consumer

---
 rtl/packet_pkg.sv | 19 +
 rtl/packet_fifo.sv | 54 +++++
 rtl/packet_consumer.sv | 147 ++++++++++++++
 tb/tb_packet_consumer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_pkg.sv
// Shared packet types and widths for the packet consumer slice.
package packet_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } packet_cmd_e;

  localparam int unsigned PKT_COUNT_W = 16;
  localparam int unsigned PKT_ADDR_W  = 32;
  localparam int unsigned PKT_DATA_W  = 32;

  typedef struct packed {
    packet_cmd_e           cmd;
    logic [PKT_ADDR_W-1:0] addr;
    logic [PKT_DATA_W-1:0] data;
  } packet_t;

endpackage

// File: rtl/packet_fifo.sv
// Receive FIFO: pointers carry one wrap bit so full and empty are distinguishable;
// the full flag is registered so nothing on the pop side reaches the put handshake.
module packet_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = full_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/packet_consumer.sv
// Packet consumer: queues incoming packets, services each one for SERVICE_CYCLES
// cycles, then reports it with a one-cycle done pulse and counts completions.
module packet_consumer
  import packet_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned SERVICE_CYCLES = 2
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   put_valid,
  output logic                   put_ready,
  input  logic                   put_cmd,
  input  logic [ADDR_W-1:0]      put_addr,
  input  logic [DATA_W-1:0]      put_data,
  output logic                   done_valid,
  output logic                   done_cmd,
  output logic [ADDR_W-1:0]      done_addr,
  output logic [DATA_W-1:0]      done_data,
  output logic [PKT_COUNT_W-1:0] pkt_count,
  output logic                   busy
);

  localparam int unsigned CNT_W = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;
  localparam int unsigned PKT_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVICE,
    ST_DONE
  } state_e;

  typedef struct packed {
    packet_cmd_e       cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pkt_t;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  pkt_t                   hold_q, hold_d;
  pkt_t                   done_pkt_q, done_pkt_d;
  logic                   done_valid_q, done_valid_d;
  logic [PKT_COUNT_W-1:0] pkt_count_q, pkt_count_d;
  logic                   ready_en_q, ready_en_d;

  pkt_t       put_pkt;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PKT_W-1:0] fifo_rdata;

  // ready_en_q keeps put_ready low through reset and for the cycle up to the first edge.
  assign put_ready = ready_en_q && !fifo_full;
  assign fifo_push = put_valid && put_ready;

  always_comb begin
    put_pkt      = '0;
    put_pkt.cmd  = packet_cmd_e'(put_cmd);
    put_pkt.addr = put_addr;
    put_pkt.data = put_data;
  end

  packet_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PKT_W)
  ) u_fifo (
    .clk   (nvdla_core_clk),
    .rst_n (nvdla_core_rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .wdata (put_pkt),
    .rdata (fifo_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    done_pkt_d   = done_pkt_q;
    done_valid_d = 1'b0;
    pkt_count_d  = pkt_count_q;
    ready_en_d   = 1'b1;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_rdata;
          cnt_d    = CNT_W'(SERVICE_CYCLES - 1);
          state_d  = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (cnt_q == '0) begin
          state_d      = ST_DONE;
          done_valid_d = 1'b1;
          done_pkt_d   = hold_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        pkt_count_d = pkt_count_q + PKT_COUNT_W'(1);
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_rdata;
          cnt_d    = CNT_W'(SERVICE_CYCLES - 1);
          state_d  = ST_SERVICE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hold_q       <= '0;
      done_pkt_q   <= '0;
      done_valid_q <= 1'b0;
      pkt_count_q  <= '0;
      ready_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      done_pkt_q   <= done_pkt_d;
      done_valid_q <= done_valid_d;
      pkt_count_q  <= pkt_count_d;
      ready_en_q   <= ready_en_d;
    end
  end

  assign done_valid = done_valid_q;
  assign done_cmd   = done_pkt_q.cmd;
  assign done_addr  = done_pkt_q.addr;
  assign done_data  = done_pkt_q.data;
  assign pkt_count  = pkt_count_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_packet_consumer.sv
// Bench for packet_consumer: random and directed traffic against a timing model
// built from the latency/throughput rules, on a default build and a SC=1/DEPTH=2 build.
module tb_packet_consumer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        pv0, pv1;
  logic        put_cmd;
  logic [31:0] put_addr, put_data;

  logic        pr0, dv0, dc0, b0;
  logic [31:0] da0, dd0;
  logic [15:0] cnt0;
  logic        pr1, dv1, dc1, b1;
  logic [31:0] da1, dd1;
  logic [15:0] cnt1;

  always #5 clk = ~clk;

  packet_consumer #(
    .DATA_W         (32),
    .ADDR_W         (32),
    .DEPTH          (4),
    .SERVICE_CYCLES (2)
  ) dut0 (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .put_valid       (pv0),
    .put_ready       (pr0),
    .put_cmd         (put_cmd),
    .put_addr        (put_addr),
    .put_data        (put_data),
    .done_valid      (dv0),
    .done_cmd        (dc0),
    .done_addr       (da0),
    .done_data       (dd0),
    .pkt_count       (cnt0),
    .busy            (b0)
  );

  packet_consumer #(
    .DATA_W         (32),
    .ADDR_W         (32),
    .DEPTH          (2),
    .SERVICE_CYCLES (1)
  ) dut1 (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .put_valid       (pv1),
    .put_ready       (pr1),
    .put_cmd         (put_cmd),
    .put_addr        (put_addr),
    .put_data        (put_data),
    .done_valid      (dv1),
    .done_cmd        (dc1),
    .done_addr       (da1),
    .done_data       (dd1),
    .pkt_count       (cnt1),
    .busy            (b1)
  );

  // Observation of whichever instance is under test.
  bit          sel;
  logic        o_ready, o_dv, o_cmd, o_busy;
  logic [31:0] o_addr, o_data;
  logic [15:0] o_cnt;
  assign o_ready = sel ? pr1  : pr0;
  assign o_dv    = sel ? dv1  : dv0;
  assign o_cmd   = sel ? dc1  : dc0;
  assign o_addr  = sel ? da1  : da0;
  assign o_data  = sel ? dd1  : dd0;
  assign o_cnt   = sel ? cnt1 : cnt0;
  assign o_busy  = sel ? b1   : b0;

  int checks = 0;
  int errors = 0;

  // Reference model: each accepted packet completes at
  // max(accept_edge + 1 + SC, previous_done_edge + SC + 1) and leaves the FIFO SC edges earlier.
  typedef struct {
    logic        c;
    logic [31:0] a;
    logic [31:0] d;
    int          done_e;
  } exp_t;

  exp_t        pend_q[$];
  int          pop_q[$];
  int          sc, depth;
  int          edge_n = 0;
  int          occ, last_done, busy_until;
  bit          exp_ready, exp_busy, inc_pending;
  logic [15:0] exp_count;
  logic        exp_cmd;
  logic [31:0] exp_addr, exp_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_clear();
    pend_q.delete();
    pop_q.delete();
    occ         = 0;
    last_done   = -1000;
    busy_until  = -1000;
    exp_ready   = 1'b0;
    exp_busy    = 1'b0;
    inc_pending = 1'b0;
    exp_count   = '0;
    exp_cmd     = 1'b0;
    exp_addr    = '0;
    exp_data    = '0;
  endtask

  task automatic check_all();
    chk("put_ready",  o_ready, exp_ready);
    chk("busy",       o_busy,  exp_busy);
    chk("pkt_count",  o_cnt,   exp_count);
    chk("done_cmd",   o_cmd,   exp_cmd);
    chk("done_addr",  o_addr,  exp_addr);
    chk("done_data",  o_data,  exp_data);
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at the next falling edge.
  task automatic step_pkt(input bit v, input logic c, input logic [31:0] a, input logic [31:0] d);
    bit acc;
    bit exp_dv;
    int done;
    put_cmd  = c;
    put_addr = a;
    put_data = d;
    pv0 = sel ? 1'b0 : v;
    pv1 = sel ? v : 1'b0;
    acc = v && exp_ready;
    @(posedge clk);
    edge_n++;
    if (inc_pending) begin
      exp_count   = exp_count + 16'd1;
      inc_pending = 1'b0;
    end
    while (pop_q.size() > 0 && pop_q[0] - sc == edge_n) begin
      busy_until = pop_q[0];
      occ--;
      void'(pop_q.pop_front());
    end
    if (acc) begin
      done = edge_n + 1 + sc;
      if (last_done + sc + 1 > done) done = last_done + sc + 1;
      last_done = done;
      occ++;
      pend_q.push_back('{c: c, a: a, d: d, done_e: done});
      pop_q.push_back(done);
    end
    exp_ready = (occ < depth);
    exp_busy  = (occ > 0) || (busy_until >= edge_n);
    @(negedge clk);
    exp_dv = (pend_q.size() > 0) && (pend_q[0].done_e == edge_n);
    if (exp_dv) begin
      exp_cmd  = pend_q[0].c;
      exp_addr = pend_q[0].a;
      exp_data = pend_q[0].d;
      void'(pend_q.pop_front());
      inc_pending = 1'b1;
    end
    chk("done_valid", o_dv, exp_dv);
    check_all();
  endtask

  task automatic step_rand(input bit v);
    step_pkt(v, 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic apply_reset();
    #2 rstn = 1'b0;
    pv0 = 1'b0;
    pv1 = 1'b0;
    model_clear();
    #1;
    chk("rst_done_valid", o_dv, 1'b0);
    check_all();
    @(negedge clk);
    chk("rst_hold_done_valid", o_dv, 1'b0);
    check_all();
    rstn = 1'b1;
  endtask

  initial begin
    rstn     = 1'b0;
    pv0      = 1'b0;
    pv1      = 1'b0;
    put_cmd  = 1'b0;
    put_addr = '0;
    put_data = '0;
    sel      = 1'b0;
    sc       = 2;
    depth    = 4;
    model_clear();

    @(negedge clk);
    apply_reset();

    // Single packet: WRITE 0x100 / 0xDEADBEEF, expected done three edges after acceptance.
    step_rand(1'b0);
    step_pkt(1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) step_rand(1'b0);
    chk("single_count", o_cnt, 16'd1);

    // Six back-to-back offers: FIFO fills, put_ready drops, pulses three cycles apart.
    for (int i = 0; i < 6; i++) step_rand(1'b1);
    for (int i = 0; i < 30; i++) step_rand(1'b0);

    // Random traffic with occasional gaps.
    for (int i = 0; i < 300; i++) step_rand($urandom_range(0, 3) != 0);
    for (int i = 0; i < 30; i++) step_rand(1'b0);

    // Counter wrap via backdoor preset while the block is idle.
    force dut0.pkt_count_q = 16'hFFFE;
    #1 release dut0.pkt_count_q;
    exp_count = 16'hFFFE;
    chk("preset_count", o_cnt, 16'hFFFE);
    step_rand(1'b1);
    for (int i = 0; i < 6; i++) step_rand(1'b0);
    chk("count_ffff", o_cnt, 16'hFFFF);
    step_rand(1'b1);
    for (int i = 0; i < 6; i++) step_rand(1'b0);
    chk("count_wrap", o_cnt, 16'h0000);

    // Reset mid-service with three entries still queued.
    for (int i = 0; i < 4; i++) step_rand(1'b1);
    chk("pre_rst_busy", o_busy, 1'b1);
    apply_reset();
    for (int i = 0; i < 12; i++) step_rand(1'b0);

    // SERVICE_CYCLES=1, DEPTH=2 build.
    sel   = 1'b1;
    sc    = 1;
    depth = 2;
    apply_reset();
    step_rand(1'b0);
    step_pkt(1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678);
    for (int i = 0; i < 5; i++) step_rand(1'b0);
    for (int i = 0; i < 10; i++) step_rand(1'b1);
    for (int i = 0; i < 10; i++) step_rand(1'b0);
    for (int i = 0; i < 200; i++) step_rand($urandom_range(0, 2) != 0);
    for (int i = 0; i < 10; i++) step_rand(1'b0);
    chk("end_idle_busy", o_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
